stage4_result_fifo: RTL and testbench
=====================================

Name: stage4_result_fifo

Overview:
Output stage directly downstream of the Stage 3 final adder in the pipelined 8-input adder tree. It consumes the registered 8-bit final sum and realigns it with a valid bit that it delays by the tree latency. Valid sums are buffered in a small FIFO and presented on a valid/ready output interface. Because the tree cannot stall, the block issues credit-based `in_ready` back to the tree's input side so that downstream backpressure never loses results.

Parameters:
- PIPE_LAT, 4, cycles from `in_valid` sampled at tree input to the matching sum on `sum_in` (min 1)
- DEPTH, 8, FIFO entries; power of 2, min 2
- AW, 3, pointer width = log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  asserted alongside the 8 operands entering Stage 1
- in_ready  output  1  credit available; upstream asserts `in_valid` only when high
- sum_in  input  8  registered final sum from the Stage 3 adder
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_data  output  8  head sum
- count  output  AW+1  FIFO occupancy
- overflow  output  1  sticky: a valid sum was dropped
- acc_clr  input  1  accumulator clear (feature only)
- acc_out  output  16  running accumulator (feature only)

Behaviour:
- Reset (`rst_n` low, async): all outputs are 0, pointers 0, valid delay line cleared, in-flight count 0. In-flight sums are discarded. Reset mid-operation loses all buffered data.
- Valid delay line: PIPE_LAT-bit shift register. Bit 0 loads `in_valid` every cycle. The push strobe is `tap = vline[PIPE_LAT-1]`.
- Push: on an edge where `tap` = 1, `sum_in` is written at `wr_ptr` and `wr_ptr` increments, wrapping mod DEPTH.
- Latency: `in_valid` sampled at edge T causes a push at edge T+PIPE_LAT. `out_valid` rises after edge T+PIPE_LAT when the FIFO was empty (no fall-through).
- Pop: on an edge where `out_valid` and `out_ready` are both 1, `rd_ptr` increments, wrapping.
- Output timing: `out_data` always equals `mem[rd_ptr]`. `out_valid` = (`count` != 0). Both are held stable while `out_ready` = 0.
- In-flight counter `infl` (width AW+1):
  - +1 when `in_valid` is sampled.
  - −1 when `tap` = 1.
  - Unchanged when both occur in the same cycle.
- `in_ready` = ((`count` + `infl`) < DEPTH), combinational from registers. A pop in the current cycle does not add credit until the next cycle.
- Full with simultaneous push and pop: both are accepted and `count` is unchanged.
- Push while full with no pop: data is dropped, pointers and `count` are unchanged, and `overflow` is set to 1 from the next edge. `overflow` clears only on reset.
- `in_valid` while `in_ready` = 0 is a protocol violation. The sample still enters the delay line and is pushed if space exists at tap time; otherwise it is dropped as above.
- Empty with pop request: no effect, since `out_valid` = 0.
- Arithmetic: sums are unsigned 8-bit and stored unmodified; the tree's carry-out is already discarded upstream.

Optional Feature:
RESULT_ACCUM_EN
- Defined:
  - On every pop, `acc_out` <= `acc_out` + {8'd0, `out_data`}, wrapping mod 2^16.
  - `acc_clr` = 1 forces `acc_out` to 0 on the next edge, with priority over an accumulate in the same cycle.
  - Reset value is 0.
- Not defined: `acc_out` is tied to 16'd0, `acc_clr` is ignored, and no accumulator register is built.

Test Plan:
- Latency: hold `out_ready` = 1 and pulse `in_valid` at edge 10 with `sum_in` = 8'h5A at edge 14 -> `out_valid` = 1 and `out_data` = 8'h5A after edge 14 for one cycle; `count` returns to 0 after edge 15.
- Credit fill: hold `out_ready` = 0 and assert `in_valid` continuously -> `in_ready` falls after 8 accepted samples; `count` reaches 8 after 4 further cycles; `overflow` stays 0.
- Full, simultaneous push and pop: with the FIFO holding 8 entries and 1 in flight, assert `out_ready` on the tap cycle -> both operations are accepted, `count` stays 8, and order is preserved (FIFO order checked 0..8).
- Overflow: force `in_valid` while `in_ready` = 0 with the FIFO full and `out_ready` = 0 -> sum 8'hFF is dropped, `overflow` = 1, and `count` stays 8.
- Reset mid-stream: drop `rst_n` asynchronously with 3 entries buffered and 2 in flight -> all outputs are immediately 0; no pushes occur after release.
- RESULT_ACCUM_EN: pop 8'hFF 300 times -> `acc_out` = (300×255) mod 65536 = 10964; asserting `acc_clr` with a simultaneous pop -> 0.

Source files
------------

// File: rtl/stage4_result_fifo.sv
// Result FIFO after the Stage 3 adder: realigns sums with delayed valids and issues tree credit.
// Optional running accumulator of popped sums is built when RESULT_ACCUM_EN is defined.
`timescale 1ns/1ps
module stage4_result_fifo #(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    sum_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          acc_clr,
  output logic [15:0]   acc_out
);

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned SW   = AW + 2;
  localparam int unsigned ACCW = 16;

  logic [PIPE_LAT-1:0] vline_q, vline_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       infl_q, infl_d;
  logic                overflow_q, overflow_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [DW-1:0]       mem_d [DEPTH];
  logic                tap, full, pop, push;
  logic [SW-1:0]       credit_sum;

  // Next-state: outputs are registered from the post-edge state so they match count/ptr exactly.
  always_comb begin
    tap        = vline_q[PIPE_LAT-1];
    full       = (count_q == CW'(DEPTH));
    pop        = out_valid_q && out_ready;
    push       = tap && (!full || pop);

    vline_d    = PIPE_LAT'({vline_q, in_valid});
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    infl_d     = infl_q;
    overflow_d = overflow_q | (tap & ~push);

    if (push) begin
      mem_d[wr_ptr_q] = sum_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({in_valid, tap})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase

    // Credit counts both buffered and in-flight sums; a pop frees credit one cycle later.
    credit_sum  = SW'(count_d) + SW'(infl_d);
    in_ready_d  = (credit_sum < SW'(DEPTH));
    out_valid_d = (count_d != '0);
    out_data_d  = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vline_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      infl_q      <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mem_q       <= '{default: '0};
    end else begin
      vline_q     <= vline_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      infl_q      <= infl_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mem_q       <= mem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef RESULT_ACCUM_EN
  logic [ACCW-1:0] acc_q, acc_d;

  // Clear wins over an accumulate in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (pop) begin
      acc_d = acc_q + ACCW'(out_data_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc_out        = ACCW'(0);
`endif

endmodule

// File: tb/tb_stage4_result_fifo.sv
// Self-checking bench for stage4_result_fifo: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_stage4_result_fifo;

  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AW       = 3;
`ifdef RESULT_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    sum_in;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [AW:0]   count;
  logic          overflow;
  logic          acc_clr;
  logic [15:0]   acc_out;

  stage4_result_fifo #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .acc_clr   (acc_clr),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: absolute due-cycle per in-flight sample, FIFO contents as a queue.
  int          cyc;
  int          due_q[$];
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [15:0] m_acc;
  int          pops;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (mq.size() + due_q.size()) < int'(DEPTH);
  endfunction

  task automatic step(input logic iv, input logic [7:0] sv, input logic ordy, input logic clr);
    bit pop;
    bit tap;
    in_valid  = iv;
    sum_in    = sv;
    out_ready = ordy;
    acc_clr   = clr;
    @(posedge clk);
    pop = (mq.size() != 0) && ordy;
    tap = (due_q.size() != 0) && (due_q[0] == cyc);
    if (clr) m_acc = 16'd0;
    else if (pop) m_acc = m_acc + 16'(mq[0]);
    if (pop) begin
      void'(mq.pop_front());
      pops++;
    end
    if (tap) begin
      void'(due_q.pop_front());
      if (mq.size() < int'(DEPTH)) mq.push_back(sv);
      else m_ovf = 1'b1;
    end
    if (iv) due_q.push_back(cyc + int'(PIPE_LAT));
    cyc++;
    #1;
    check("out_valid", out_valid, mq.size() != 0);
    check("count", count, mq.size());
    check("in_ready", in_ready, model_ready());
    check("overflow", overflow, m_ovf);
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    check("acc_out", acc_out, ACC_EN ? m_acc : 16'd0);
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = 8'd0;
    acc_clr   = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_acc_out", acc_out, 0);
    due_q.delete();
    mq.delete();
    m_ovf = 1'b0;
    m_acc = 16'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       accepted;
    int       sent;
    logic     iv;
    logic [6:0] pat;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = 8'd0;
    acc_clr   = 1'b0;
    cyc       = 0;
    m_ovf     = 1'b0;
    m_acc     = 16'd0;
    pops      = 0;
    n_assert  = 0;
    n_fail    = 0;

    apply_reset();
    repeat (3) step(1'b0, 8'($urandom), 1'b1, 1'b0);

    // Latency: single sample, sum appears PIPE_LAT edges later for one cycle.
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h5A, 1'b1, 1'b0);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h5A);
    step(1'b0, 8'($urandom), 1'b1, 1'b0);
    check("lat_drain", count, 0);

    // Credit fill with consumer stalled.
    accepted = 0;
    for (int i = 0; i < 20 && in_ready; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      accepted++;
    end
    check("fill_accepted", accepted, 8);
    repeat (4) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    check("fill_count", count, 8);
    check("fill_ovf", overflow, 0);

    // Full FIFO, one extra in flight, pop on the tap cycle.
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'hC3, 1'b1, 1'b0);
    check("fpp_count", count, 8);
    check("fpp_ovf", overflow, 0);

    // Overflow: push onto a full FIFO with no pop.
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 8);
    repeat (10) step(1'b0, 8'($urandom), 1'b1, 1'b0);
    check("drain_count", count, 0);

    // Random traffic with occasional protocol violations and clears.
    for (int i = 0; i < 400; i++) begin
      if (model_ready()) iv = 1'($urandom_range(0, 1));
      else iv = ($urandom_range(0, 15) == 0);
      step(iv, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end
    repeat (12) step(1'b0, 8'($urandom), 1'b1, 1'b0);
    check("rand_drain", count, 0);

    // Accumulator: clear, then 300 pops of 0xFF.
    step(1'b0, 8'($urandom), 1'b1, 1'b1);
    sent = 0;
    pops = 0;
    for (int i = 0; i < 2000 && pops < 300; i++) begin
      iv = model_ready() && (sent < 300);
      step(iv, 8'hFF, 1'b1, 1'b0);
      if (iv) sent++;
    end
    check("acc_300", acc_out, ACC_EN ? 16'd10964 : 16'd0);

    // Clear takes priority over a simultaneous accumulate.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h22, 1'b1, 1'b0);
    check("clr_head", out_data, 8'h22);
    step(1'b0, 8'($urandom), 1'b1, 1'b1);
    check("acc_clr_pop", acc_out, 0);

    // Reset with 3 buffered and 2 in flight.
    pat = 7'b1110011;
    for (int i = 0; i < 7; i++) step(pat[6-i], 8'($urandom), 1'b0, 1'b0);
    check("pre_rst_count", count, 3);
    apply_reset();
    repeat (8) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    check("post_rst_count", count, 0);
    check("post_rst_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
